// File: rtl/wr_arria10_phy_reset_ctrl_pkg.sv
// Shared types and constants for the Arria 10 WR PHY reset sequencer.
// Holds the FSM state enums, default timing constants and a width helper.
package wr_arria10_phy_pkg;

  localparam int unsigned AnalogHoldDefault   = 16;
  localparam int unsigned DigitalSettleDefault = 64;
  localparam int unsigned LockTimeoutDefault  = 65536;

  typedef enum logic [1:0] {
    TxReset,
    TxWaitCal,
    TxDigHold,
    TxReady
  } t_tx_rst_state;

  typedef enum logic [2:0] {
    RxReset,
    RxWaitCal,
    RxWaitLock,
    RxDigHold,
    RxReady
  } t_rx_rst_state;

  // Bits needed to count from 0 to value-1; never returns zero.
  function automatic int unsigned f_ceil_log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/gc_sync_ffs.sv
// Two-flop synchronizer for a single asynchronous level into clk_i.
module gc_sync_ffs (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
  output logic synced_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= data_i;
      r_sync <= r_meta;
    end
  end

  assign synced_o = r_sync;

endmodule

// File: rtl/wr_arria10_phy_reset_ctrl.sv
// Reset sequencer for the Arria 10 single-lane WR transceiver PHY.
// Independent TX and RX FSMs; every PHY-facing output is a registered state decode.
module wr_arria10_phy_reset_ctrl
  import wr_arria10_phy_pkg::*;
#(
  parameter int unsigned g_analog_hold    = AnalogHoldDefault,
  parameter int unsigned g_digital_settle = DigitalSettleDefault,
  parameter int unsigned g_lock_timeout   = LockTimeoutDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pll_locked_i,
  input  logic tx_cal_busy_i,
  input  logic rx_cal_busy_i,
  input  logic rx_is_lockedtodata_i,
  input  logic link_rst_i,
  output logic tx_analogreset_o,
  output logic tx_digitalreset_o,
  output logic rx_analogreset_o,
  output logic rx_digitalreset_o,
  output logic rx_set_locktodata_o,
  output logic rx_set_locktoref_o,
  output logic tx_ready_o,
  output logic rx_ready_o
);

  localparam int unsigned CntMax0 =
      (g_analog_hold > g_digital_settle) ? g_analog_hold : g_digital_settle;
  localparam int unsigned CntMax  = (CntMax0 > g_lock_timeout) ? CntMax0 : g_lock_timeout;
  localparam int unsigned CntW    = f_ceil_log2(CntMax);

  localparam logic [CntW-1:0] HoldLast    = CntW'(g_analog_hold - 1);
  localparam logic [CntW-1:0] SettleLast  = CntW'(g_digital_settle - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(g_lock_timeout - 1);

  logic w_pll_locked, w_tx_cal_busy, w_rx_cal_busy, w_rx_locked;

  gc_sync_ffs u_sync_pll (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (pll_locked_i),
    .synced_o(w_pll_locked)
  );

  gc_sync_ffs u_sync_tx_cal (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (tx_cal_busy_i),
    .synced_o(w_tx_cal_busy)
  );

  gc_sync_ffs u_sync_rx_cal (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (rx_cal_busy_i),
    .synced_o(w_rx_cal_busy)
  );

  gc_sync_ffs u_sync_rx_lock (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (rx_is_lockedtodata_i),
    .synced_o(w_rx_locked)
  );

  t_tx_rst_state   r_tx_state, w_tx_state_d;
  t_rx_rst_state   r_rx_state, w_rx_state_d;
  logic [CntW-1:0] r_tx_cnt, w_tx_cnt_d;
  logic [CntW-1:0] r_rx_cnt, w_rx_cnt_d;
  logic            r_tx_analogreset, r_tx_digitalreset, r_tx_ready;
  logic            r_rx_analogreset, r_rx_digitalreset, r_rx_ready;

  always_comb begin
    w_tx_state_d = r_tx_state;
    unique case (r_tx_state)
      TxReset:   if (r_tx_cnt >= HoldLast && w_pll_locked) w_tx_state_d = TxWaitCal;
      TxWaitCal: if (!w_tx_cal_busy) w_tx_state_d = TxDigHold;
      TxDigHold: begin
        if (w_tx_cal_busy)                w_tx_state_d = TxWaitCal;
        else if (r_tx_cnt >= SettleLast)  w_tx_state_d = TxReady;
      end
      TxReady: begin
        if (!w_pll_locked)      w_tx_state_d = TxReset;
        else if (w_tx_cal_busy) w_tx_state_d = TxWaitCal;
      end
      default: w_tx_state_d = TxReset;
    endcase
    if (link_rst_i) w_tx_state_d = TxReset;

    // Counter restarts on every state entry and saturates at all-ones.
    if (link_rst_i || w_tx_state_d != r_tx_state) w_tx_cnt_d = '0;
    else if (&r_tx_cnt)                           w_tx_cnt_d = r_tx_cnt;
    else                                          w_tx_cnt_d = r_tx_cnt + 1'b1;
  end

  always_comb begin
    w_rx_state_d = r_rx_state;
    unique case (r_rx_state)
      RxReset:   if (r_rx_cnt >= HoldLast) w_rx_state_d = RxWaitCal;
      RxWaitCal: if (!w_rx_cal_busy) w_rx_state_d = RxWaitLock;
      RxWaitLock: begin
        if (w_rx_locked)                  w_rx_state_d = RxDigHold;
        else if (r_rx_cnt >= TimeoutLast) w_rx_state_d = RxReset;
      end
      RxDigHold: begin
        if (w_rx_cal_busy)                w_rx_state_d = RxWaitCal;
        else if (r_rx_cnt >= SettleLast)  w_rx_state_d = RxReady;
      end
      RxReady: begin
        if (!w_rx_locked)       w_rx_state_d = RxReset;
        else if (w_rx_cal_busy) w_rx_state_d = RxWaitCal;
      end
      default: w_rx_state_d = RxReset;
    endcase
    if (link_rst_i) w_rx_state_d = RxReset;

    if (link_rst_i || w_rx_state_d != r_rx_state) w_rx_cnt_d = '0;
    else if (&r_rx_cnt)                           w_rx_cnt_d = r_rx_cnt;
    else                                          w_rx_cnt_d = r_rx_cnt + 1'b1;
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state        <= TxReset;
      r_rx_state        <= RxReset;
      r_tx_cnt          <= '0;
      r_rx_cnt          <= '0;
      r_tx_analogreset  <= 1'b1;
      r_tx_digitalreset <= 1'b1;
      r_tx_ready        <= 1'b0;
      r_rx_analogreset  <= 1'b1;
      r_rx_digitalreset <= 1'b1;
      r_rx_ready        <= 1'b0;
    end else begin
      r_tx_state        <= w_tx_state_d;
      r_rx_state        <= w_rx_state_d;
      r_tx_cnt          <= w_tx_cnt_d;
      r_rx_cnt          <= w_rx_cnt_d;
      r_tx_analogreset  <= (w_tx_state_d == TxReset);
      r_tx_digitalreset <= (w_tx_state_d != TxReady);
      r_tx_ready        <= (w_tx_state_d == TxReady);
      r_rx_analogreset  <= (w_rx_state_d == RxReset);
      r_rx_digitalreset <= (w_rx_state_d != RxReady);
      r_rx_ready        <= (w_rx_state_d == RxReady);
    end
  end

  assign tx_analogreset_o    = r_tx_analogreset;
  assign tx_digitalreset_o   = r_tx_digitalreset;
  assign rx_analogreset_o    = r_rx_analogreset;
  assign rx_digitalreset_o   = r_rx_digitalreset;
  assign tx_ready_o          = r_tx_ready;
  assign rx_ready_o          = r_rx_ready;
  assign rx_set_locktodata_o = 1'b0;
  assign rx_set_locktoref_o  = 1'b0;

endmodule

// File: tb/tb_wr_arria10_phy_reset_ctrl.sv
// Bench for the PHY reset sequencer: directed and random stimulus compared every
// cycle against a timestamp-based model of the reset sequence.
module tb_wr_arria10_phy_reset_ctrl;

  localparam int unsigned H = 8;
  localparam int unsigned S = 16;
  localparam int unsigned T = 100;

  logic clk = 1'b0;
  logic rst, pll, txcal, rxcal, lock, link;
  logic tx_a, tx_d, rx_a, rx_d, set_ltd, set_ltr, tx_rdy, rx_rdy;

  always #5 clk = ~clk;

  wr_arria10_phy_reset_ctrl #(
    .g_analog_hold   (H),
    .g_digital_settle(S),
    .g_lock_timeout  (T)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .pll_locked_i        (pll),
    .tx_cal_busy_i       (txcal),
    .rx_cal_busy_i       (rxcal),
    .rx_is_lockedtodata_i(lock),
    .link_rst_i          (link),
    .tx_analogreset_o    (tx_a),
    .tx_digitalreset_o   (tx_d),
    .rx_analogreset_o    (rx_a),
    .rx_digitalreset_o   (rx_d),
    .rx_set_locktodata_o (set_ltd),
    .rx_set_locktoref_o  (set_ltr),
    .tx_ready_o          (tx_rdy),
    .rx_ready_o          (rx_rdy)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Model: phase index plus the edge number at which the phase was entered.
  // TX phases 0..3 = reset, wait cal, digital hold, ready.
  // RX phases 0..4 = reset, wait cal, wait lock, digital hold, ready.
  int e = 0;
  int tx_ph = 0, rx_ph = 0, tx_t0 = 0, rx_t0 = 0;
  logic [3:0] dq[$];

  task automatic model_step();
    logic [3:0] d;
    int age, nph;
    e++;
    if (rst) begin
      tx_ph = 0; rx_ph = 0; tx_t0 = e; rx_t0 = e;
      dq.delete(); dq.push_back(4'b0); dq.push_back(4'b0);
      return;
    end
    d = dq.pop_front();              // inputs as seen two edges after being driven
    dq.push_back({pll, txcal, rxcal, lock});
    if (link) begin
      tx_ph = 0; rx_ph = 0; tx_t0 = e; rx_t0 = e;
      return;
    end
    age = e - tx_t0;
    nph = tx_ph;
    case (tx_ph)
      0: if (age >= H && d[3]) nph = 1;
      1: if (!d[2]) nph = 2;
      2: nph = d[2] ? 1 : (age >= S ? 3 : 2);
      default: nph = !d[3] ? 0 : (d[2] ? 1 : 3);
    endcase
    if (nph != tx_ph) begin tx_ph = nph; tx_t0 = e; end
    age = e - rx_t0;
    nph = rx_ph;
    case (rx_ph)
      0: if (age >= H) nph = 1;
      1: if (!d[1]) nph = 2;
      2: nph = d[0] ? 3 : (age >= T ? 0 : 2);
      3: nph = d[1] ? 1 : (age >= S ? 4 : 3);
      default: nph = !d[0] ? 0 : (d[1] ? 1 : 4);
    endcase
    if (nph != rx_ph) begin rx_ph = nph; rx_t0 = e; end
  endtask

  function automatic logic [7:0] expected();
    return {tx_ph == 0, tx_ph != 3, rx_ph == 0, rx_ph != 4, 1'b0, 1'b0, tx_ph == 3, rx_ph == 4};
  endfunction

  task automatic tick();
    logic [7:0] obs, exp_v;
    @(posedge clk);
    model_step();
    #1;
    obs   = {tx_a, tx_d, rx_a, rx_d, set_ltd, set_ltr, tx_rdy, rx_rdy};
    exp_v = expected();
    n_vec++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL outputs edge=%0d observed=%b expected=%b", e, obs, exp_v);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp_b);
    n_vec++;
    assert (obs === exp_b) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_b);
    end
  endtask

  initial begin
    logic found;
    rst = 1'b1; pll = 1'b0; txcal = 1'b0; rxcal = 1'b0; lock = 1'b0; link = 1'b0;
    dq.push_back(4'b0); dq.push_back(4'b0);
    repeat (3) tick();

    // Clean bring-up, CDR locks at cycle 40.
    pll = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 40) lock = 1'b1;
      tick();
    end
    check_bit("bringup_tx_ready", tx_rdy, 1'b1);
    check_bit("bringup_rx_ready", rx_rdy, 1'b1);

    // One-cycle lock loss while ready.
    lock = 1'b0; tick(); lock = 1'b1;
    repeat (40) tick();
    check_bit("lockloss_tx_ready", tx_rdy, 1'b1);

    // link_rst_i coinciding with RX digital hold -> ready.
    lock = 1'b0; tick(); lock = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (rx_ph == 3 && (e + 1 - rx_t0) >= S) found = 1'b1;
      else tick();
    end
    check_bit("dighold_reached", found, 1'b1);
    link = 1'b1; tick(); link = 1'b0;
    check_bit("linkrst_rx_ready", rx_rdy, 1'b0);
    check_bit("linkrst_tx_areset", tx_a, 1'b1);
    repeat (60) tick();

    // CDR timeout: lock never comes.
    lock = 1'b0;
    repeat (330) tick();
    check_bit("timeout_rx_ready", rx_rdy, 1'b0);

    // PLL late after a fresh reset.
    rst = 1'b1; pll = 1'b0; lock = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (i == 50) pll = 1'b1;
      tick();
    end

    // rst_i while both paths ready.
    check_bit("pre_rst_tx_ready", tx_rdy, 1'b1);
    rst = 1'b1; tick();
    check_bit("rst_tx_ready", tx_rdy, 1'b0);
    check_bit("rst_rx_areset", rx_a, 1'b1);
    rst = 1'b0;

    // Random stress with rare glitches on every input.
    for (int i = 0; i < 2000; i++) begin
      pll   = ($urandom_range(0, 199) != 0);
      txcal = ($urandom_range(0, 119) == 0);
      rxcal = ($urandom_range(0, 119) == 0);
      lock  = ($urandom_range(0, 149) != 0);
      link  = ($urandom_range(0, 399) == 0);
      rst   = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wr_arria10_phy_reset_ctrl.md
# wr_arria10_phy_reset_ctrl

Reset sequencer for the Arria 10 single-lane WR transceiver PHY. It drives the PHY's four analog and digital reset inputs and its CDR lock-mode controls. It consumes the PHY's calibration-busy and lock status, plus the TX PLL lock. It sits between the WR PHY wrapper's system-clock logic and the transceiver instance, and reports per-direction readiness to the endpoint.

## Interface
Parameters:
- g_analog_hold, 16: minimum cycles tx/rx analog reset stays asserted after entry to a reset state.
- g_digital_settle, 64: cycles between analog reset release (with cal done) and digital reset release.
- g_lock_timeout, 65536: cycles allowed in RX_WAIT_LOCK before the RX path restarts.

Ports:
- clk_i  in  1  free-running system clock; all logic is in this domain.
- rst_i  in  1  synchronous, active-high reset.
- pll_locked_i  in  1  TX PLL lock; asynchronous.
- tx_cal_busy_i  in  1  PHY TX calibration busy; asynchronous.
- rx_cal_busy_i  in  1  PHY RX calibration busy; asynchronous.
- rx_is_lockedtodata_i  in  1  CDR locked to data; asynchronous.
- link_rst_i  in  1  one-cycle request to restart both paths.
- tx_analogreset_o  out  1  to PHY.
- tx_digitalreset_o  out  1  to PHY.
- rx_analogreset_o  out  1  to PHY.
- rx_digitalreset_o  out  1  to PHY.
- rx_set_locktodata_o  out  1  to PHY; constant 0 (automatic CDR mode).
- rx_set_locktoref_o  out  1  to PHY; constant 0.
- tx_ready_o  out  1  TX path usable.
- rx_ready_o  out  1  RX path usable.

## Operation
- Asynchronous inputs pass through 2-flop synchronizers before any use.
- Two independent FSMs share one rule: every output is a registered decode of the FSM state.
- TX FSM:
  - TX_RESET: analog=1, digital=1. Counter counts up. Leave when counter reaches g_analog_hold-1 AND pll_locked is high.
  - TX_WAIT_CAL: analog=0, digital=1. Leave when tx_cal_busy is low. Counter clears on entry.
  - TX_DIG_HOLD: digital=1. Leave when counter reaches g_digital_settle-1.
  - TX_READY: all resets 0, tx_ready_o=1. Loss of pll_locked returns the FSM to TX_RESET.
- RX FSM:
  - RX_RESET: analog=1, digital=1. Exit condition is the TX_RESET hold count only; the RX FSM does not depend on pll_locked.
  - RX_WAIT_CAL: analog=0. Leave when rx_cal_busy is low.
  - RX_WAIT_LOCK: digital=1. Leave when rx_is_lockedtodata is high. If the counter reaches g_lock_timeout-1 first, return to RX_RESET.
  - RX_DIG_HOLD: settle exactly as in TX_DIG_HOLD.
  - RX_READY: rx_ready_o=1. Loss of lockedtodata returns the FSM to RX_RESET.
- link_rst_i sends both FSMs to their RESET states from any state and clears the counters.
- If link_rst_i and a normal transition occur in the same cycle, link_rst_i wins.
- Cal-busy reasserting in a DIG_HOLD or READY state returns that path to its WAIT_CAL state.
- Counters saturate. They are sized ceil_log2 of the largest parameter.

## Timing
- Reset values: all four PHY resets 1, both ready outputs 0, both set_lock outputs 0, FSMs in their RESET states, counters 0, synchronizers 0.
- rst_i asserted mid-operation forces the reset values on the next edge.
- Synchronizer latency is 2 cycles.
- Minimum TX path: g_analog_hold cycles in reset + ≥1 cycle in WAIT_CAL + g_digital_settle cycles → tx_ready_o.
- An input event (lock loss, cal busy) reaches the outputs 3 cycles later: 2 synchronizer cycles + 1 state register.
- Ready outputs fall in the same cycle the PHY resets rise.

## Structure
- Shared package wr_arria10_phy_pkg:
  - FSM state enum types t_tx_rst_state and t_rx_rst_state.
  - Function f_ceil_log2.
  - Default parameter constants.
- Synchronizers: four instances of the existing gc_sync_ffs sub-module. No other sub-modules.

## Test plan
All scenarios use g_analog_hold=8, g_digital_settle=16, g_lock_timeout=100.
- Clean bring-up: pll_locked high, cal_busy low from start, lockedtodata high at cycle 40 → tx_ready_o rises at cycle 26±1; rx_ready_o rises 19±1 cycles after cycle 40.
- PLL late: pll_locked rises at cycle 50 → tx_analogreset_o stays 1 until cycle 53.
- CDR timeout: lockedtodata held low → rx_analogreset_o re-pulses every ~110 cycles; rx_ready_o never rises.
- Lock loss in READY: drop lockedtodata for 1 cycle → rx_ready_o falls 3 cycles later, rx_analogreset_o rises in the same cycle, and the full RX sequence repeats; tx_ready_o stays 1.
- link_rst_i pulse coinciding with a RX_DIG_HOLD→RX_READY transition → both FSMs go to RESET, and ready outputs stay 0 until the sequence completes.
- rst_i asserted while READY → all outputs at reset values after 1 edge.
